// File: rtl/button_debounce.sv
// Synchronizes and debounces NUM_BTN raw push-button/switch inputs, producing a
// clean level, one-cycle press/release strobes and a press-toggled latch per channel.
module button_debounce #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_toggle
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
    logic [NUM_BTN-1:0] sync;

    logic [CNT_W-1:0]   cnt     [NUM_BTN];
    logic [CNT_W-1:0]   cnt_nxt [NUM_BTN];
    logic [NUM_BTN-1:0] state_nxt;
    logic [NUM_BTN-1:0] press_nxt;
    logic [NUM_BTN-1:0] release_nxt;

    assign sync = sync_q[SYNC_STAGES-1];

    // Synchronizer chain
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= btn_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Stability counter: any return to the accepted level restarts qualification
    always_comb begin
        state_nxt   = btn_state;
        press_nxt   = '0;
        release_nxt = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_nxt[i] = cnt[i];
            if (sync[i] == btn_state[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                cnt_nxt[i]     = '0;
                state_nxt[i]   = sync[i];
                press_nxt[i]   = sync[i];
                release_nxt[i] = ~sync[i];
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Debounced outputs, strobes registered alongside the level
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
            btn_state   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_toggle  <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            btn_state   <= state_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
            btn_toggle  <= btn_toggle ^ press_nxt;
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: a run-length reference model predicts every
// cycle's outputs, plus directed latency/strobe checks for the debounce scenarios.
module tb_button_debounce;

    localparam int NB = 4;
    localparam int DC = 8;
    localparam int SS = 2;

    logic          clk_100MHz;
    logic          reset;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_state;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_toggle;

    button_debounce #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DC),
        .SYNC_STAGES    (SS)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .btn_in     (btn_in),
        .btn_state  (btn_state),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_toggle (btn_toggle)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [NB-1:0] m_pipe0, m_pipe1, m_st, m_tog;
    int            m_run [NB];
    logic [15:0]   exp_q [$];

    // observation bookkeeping
    int            n_press [NB];
    int            n_rel   [NB];
    int            n_wide;
    int            n_both;
    logic [NB-1:0] prev_press, prev_rel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [NB-1:0] b, input logic r, output logic [15:0] e);
        logic [NB-1:0] s_old, prs, rel;
        prs = '0;
        rel = '0;
        if (r) begin
            m_pipe0 = '0;
            m_pipe1 = '0;
            m_st    = '0;
            m_tog   = '0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
        end else begin
            s_old = m_pipe1;
            for (int i = 0; i < NB; i++) begin
                if (s_old[i] !== m_st[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_run[i] = 0;
                        m_st[i]  = s_old[i];
                        if (s_old[i]) begin
                            prs[i]   = 1'b1;
                            m_tog[i] = ~m_tog[i];
                        end else begin
                            rel[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_pipe1 = m_pipe0;
            m_pipe0 = b;
        end
        e = {m_st, prs, rel, m_tog};
    endtask

    // one clock: drive after negedge, predict, compare #1 after posedge
    task automatic step(input logic [NB-1:0] b, input logic r);
        logic [15:0] e, o;
        btn_in = b;
        reset  = r;
        model_edge(b, r, e);
        exp_q.push_back(e);
        @(posedge clk_100MHz);
        #1;
        o = {btn_state, btn_press, btn_release, btn_toggle};
        e = exp_q.pop_front();
        check("cycle", 32'(o), 32'(e));
        for (int i = 0; i < NB; i++) begin
            if (btn_press[i]) n_press[i]++;
            if (btn_release[i]) n_rel[i]++;
            if (btn_press[i] && prev_press[i]) n_wide++;
            if (btn_release[i] && prev_rel[i]) n_wide++;
            if (btn_press[i] && btn_release[i]) n_both++;
        end
        prev_press = btn_press;
        prev_rel   = btn_release;
        @(negedge clk_100MHz);
    endtask

    task automatic hold(input logic [NB-1:0] b, input int n);
        for (int k = 0; k < n; k++) step(b, 1'b0);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NB; i++) begin
            n_press[i] = 0;
            n_rel[i]   = 0;
        end
        n_wide = 0;
        n_both = 0;
    endtask

    task automatic do_reset();
        step('0, 1'b1);
        check("reset_out", 32'({btn_state, btn_press, btn_release, btn_toggle}), 32'h0);
        clear_counts();
    endtask

    // drive b until channel ch reads lvl; returns edges taken (bounded)
    task automatic edges_until(input logic [NB-1:0] b, input int ch, input logic lvl,
                               output int edges);
        edges = 0;
        do begin
            step(b, 1'b0);
            edges++;
        end while (btn_state[ch] !== lvl && edges < 40);
    endtask

    initial begin
        int ed;
        int seen_hi;
        btn_in     = '0;
        reset      = 1'b1;
        prev_press = '0;
        prev_rel   = '0;
        clear_counts();
        @(negedge clk_100MHz);
        do_reset();
        step('0, 1'b1);

        // 1: single channel press latency and strobe
        do_reset();
        edges_until(4'b0001, 0, 1'b1, ed);
        check("s1_latency", 32'(ed), 32'd10);
        check("s1_press", 32'(btn_press), 32'h1);
        check("s1_toggle", 32'(btn_toggle), 32'h1);
        check("s1_state_all", 32'(btn_state), 32'h1);
        step(4'b0001, 1'b0);
        check("s1_press_gone", 32'(btn_press), 32'h0);
        hold('0, 12);
        check("s1_released", 32'(btn_state), 32'h0);

        // 2: bounce on channel 1
        do_reset();
        hold(4'b0010, 3);
        hold(4'b0000, 2);
        hold(4'b0010, 5);
        hold(4'b0000, 1);
        check("s2_no_strobe_bounce", 32'(n_press[1]), 32'd0);
        edges_until(4'b0010, 1, 1'b1, ed);
        check("s2_latency", 32'(ed), 32'd10);
        hold(4'b0010, 5);
        check("s2_press_count", 32'(n_press[1]), 32'd1);

        // 3: glitch shorter than the window, then exactly the window
        do_reset();
        hold(4'b0100, 7);
        hold(4'b0000, 15);
        check("s3_glitch_press", 32'(n_press[2]), 32'd0);
        check("s3_glitch_state", 32'(btn_state), 32'h0);
        check("s3_glitch_toggle", 32'(btn_toggle), 32'h0);
        hold(4'b0100, 8);
        seen_hi = 0;
        ed      = 0;
        do begin
            step(4'b0000, 1'b0);
            ed++;
            if (btn_state[2]) seen_hi = 1;
        end while (!(seen_hi == 1 && btn_state[2] == 1'b0) && ed < 40);
        check("s3_accepted", 32'(seen_hi), 32'd1);
        check("s3_fall_latency", 32'(ed), 32'd10);
        check("s3_release_count", 32'(n_rel[2]), 32'd1);
        check("s3_press_count", 32'(n_press[2]), 32'd1);

        // 4: all channels at once
        do_reset();
        hold('0, 2);
        edges_until(4'b1111, 0, 1'b1, ed);
        check("s4_latency", 32'(ed), 32'd10);
        check("s4_state", 32'(btn_state), 32'hF);
        check("s4_press", 32'(btn_press), 32'hF);
        check("s4_toggle", 32'(btn_toggle), 32'hF);
        hold(4'b1111, 2);

        // 5: three press/release cycles on channel 3
        do_reset();
        hold(4'b1000, 12);
        check("s5_tog1", 32'(btn_toggle[3]), 32'd1);
        hold(4'b0000, 12);
        hold(4'b1000, 12);
        check("s5_tog2", 32'(btn_toggle[3]), 32'd0);
        hold(4'b0000, 12);
        hold(4'b1000, 12);
        check("s5_tog3", 32'(btn_toggle[3]), 32'd1);
        hold(4'b0000, 12);
        check("s5_presses", 32'(n_press[3]), 32'd3);
        check("s5_releases", 32'(n_rel[3]), 32'd3);
        check("s5_wide_strobes", 32'(n_wide), 32'd0);
        check("s5_press_and_release", 32'(n_both), 32'd0);

        // 6: reset mid-count forces full requalification
        do_reset();
        hold(4'b0001, 7);
        step(4'b0001, 1'b1);
        check("s6_reset_out", 32'({btn_state, btn_press, btn_release, btn_toggle}), 32'h0);
        edges_until(4'b0001, 0, 1'b1, ed);
        check("s6_latency", 32'(ed), 32'd10);
        check("s6_press", 32'(btn_press), 32'h1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
